// File: rtl/wave_copy_sequencer.sv
// wave_copy_sequencer
//   Copies a wave table from the main sample memory into the wave BRAM bank
//   (oscillator, visual and debug write ports). A single-cycle start_in
//   latches a source base, a sample count and a destination mask. The block
//   then issues one read per cycle, waits out the source RAM read latency,
//   and fans each returned sample out to the selected destinations at
//   addresses 0..W-1. It is the only writer of those BRAMs.
//
// Optional feature (macro WAVE_COPY_SUM_EN):
//   When defined, sum_out carries the 32-bit wrapping sum of the samples
//   delivered by the last completed copy. It updates together with done_out.
//   When undefined, the port and its accumulator are absent.
//
// Ports
//   clk_in        system clock
//   rst_n_in      asynchronous reset, active-low
//   start_in      copy request; accepted in every state (aborts a running copy)
//   src_base_in   first source address
//   width_in      number of samples to copy
//   dest_mask_in  destinations to write
//   src_addr_out  main memory read address
//   src_en_out    main memory read enable
//   src_data_in   main memory read data, READ_LATENCY cycles after src_en_out
//   dst_addr_out  shared destination write address
//   dst_data_out  shared destination write data
//   dst_we_out    per-destination write enable
//   busy_out      copy in progress (reading or draining)
//   done_out      one-cycle completion pulse
//   sum_out       (WAVE_COPY_SUM_EN only) sample sum of the last completed copy

module wave_copy_sequencer #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int WW_WIDTH       = 18,
  parameter int SRC_ADDR_WIDTH = 18,
  parameter int READ_LATENCY   = 2,
  parameter int NUM_DEST       = 3
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      start_in,
  input  logic [SRC_ADDR_WIDTH-1:0] src_base_in,
  input  logic [WW_WIDTH-1:0]       width_in,
  input  logic [NUM_DEST-1:0]       dest_mask_in,
  output logic [SRC_ADDR_WIDTH-1:0] src_addr_out,
  output logic                      src_en_out,
  input  logic [SAMPLE_WIDTH-1:0]   src_data_in,
  output logic [WW_WIDTH-1:0]       dst_addr_out,
  output logic [SAMPLE_WIDTH-1:0]   dst_data_out,
  output logic [NUM_DEST-1:0]       dst_we_out,
  output logic                      busy_out,
  output logic                      done_out
`ifdef WAVE_COPY_SUM_EN
  ,
  output logic [31:0]               sum_out
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]                state_q;
  logic [1:0]                state_nxt;
  logic [SRC_ADDR_WIDTH-1:0] base_q;
  logic [WW_WIDTH-1:0]       width_q;
  logic [NUM_DEST-1:0]       mask_q;
  logic [WW_WIDTH-1:0]       rd_idx_q;
  logic [READ_LATENCY-1:0]   pipe_valid_q;
  logic [READ_LATENCY-1:0]   pipe_valid_nxt;
  logic [READ_LATENCY-1:0]   pipe_shift;
  logic [WW_WIDTH-1:0]       pipe_idx_q [READ_LATENCY];

  logic busy;
  logic issue;
  logic abort;
  logic last_read;
  logic wr_valid;

  assign busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign issue     = (state_q == ST_READ);
  assign abort     = start_in && busy;
  assign last_read = (rd_idx_q == width_q - WW_WIDTH'(1));

  // Valid bits after this edge, ignoring the read that may enter stage 0.
  // When this is zero in DRAIN, the exit stage holds the final write.
  assign pipe_shift = pipe_valid_q << 1;

  // An abort kills the write that is leaving the pipeline in the same cycle,
  // so nothing from the old copy reaches the BRAMs once a restart is seen.
  assign wr_valid = pipe_valid_q[READ_LATENCY-1] && !abort;

  // Next-state logic. A start request wins in every state: from IDLE/DONE it
  // begins a copy, and from READ/DRAIN it aborts and restarts.
  always_comb begin
    state_nxt = state_q;
    if (start_in) begin
      state_nxt = (width_in != '0) ? ST_READ : ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_READ:  state_nxt = last_read ? ST_DRAIN : ST_READ;
        ST_DRAIN: state_nxt = (pipe_shift == '0) ? ST_DONE : ST_DRAIN;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // The valid shift register mirrors the source RAM latency. An abort flushes it.
  always_comb begin
    pipe_valid_nxt = abort ? '0 : (pipe_shift | READ_LATENCY'(issue));
  end

  // State, copy parameters, read index and latency-matching pipeline.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      width_q      <= '0;
      mask_q       <= '0;
      rd_idx_q     <= '0;
      pipe_valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_idx_q[i] <= '0;
      end
    end else begin
      state_q      <= state_nxt;
      pipe_valid_q <= pipe_valid_nxt;
      if (start_in) begin
        base_q   <= src_base_in;
        width_q  <= width_in;
        mask_q   <= dest_mask_in;
        rd_idx_q <= '0;
      end else if (issue) begin
        rd_idx_q <= rd_idx_q + WW_WIDTH'(1);
      end
      pipe_idx_q[0] <= rd_idx_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
    end
  end

  // Source address wraps naturally at 2^SRC_ADDR_WIDTH. Outputs are zero
  // outside their active windows, so reset clears them immediately.
  assign src_en_out   = issue;
  assign src_addr_out = issue ? (base_q + SRC_ADDR_WIDTH'(rd_idx_q)) : '0;
  assign dst_we_out   = wr_valid ? mask_q : '0;
  assign dst_addr_out = wr_valid ? pipe_idx_q[READ_LATENCY-1] : '0;
  assign dst_data_out = wr_valid ? src_data_in : '0;
  assign busy_out     = busy;
  assign done_out     = (state_q == ST_DONE);

`ifdef WAVE_COPY_SUM_EN
  logic [31:0] acc_q;
  logic [31:0] acc_nxt;
  logic [31:0] sum_q;

  // The accumulator restarts on every accepted start. This means an aborted
  // copy's partial sum is discarded and never reaches sum_out.
  always_comb begin
    acc_nxt = acc_q;
    if (start_in) begin
      acc_nxt = '0;
    end else if (wr_valid) begin
      acc_nxt = acc_q + 32'(src_data_in);
    end
  end

  // sum_out is loaded on the edge that enters DONE, so it changes with done_out.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_nxt;
      if (state_nxt == ST_DONE) begin
        sum_q <= acc_nxt;
      end
    end
  end

  assign sum_out = sum_q;
`endif

endmodule
